clip_recorder_ctrl: RTL and testbench
=====================================

Name: clip_recorder_ctrl

Overview:
Parametrised multi-clip record/play controller for the voice-recorder datapath. It sequences record, play and erase operations over NUM_CLIPS fixed-size clip slots in sample memory. It generates memory addresses and write strobes per sample tick, and tracks recorded length and validity per clip. It sits between the user-input debouncers and the sample RAM / codec enables.

Parameters:
NUM_CLIPS, 4, number of clip slots (>=2)
CLIP_SECONDS, 8, maximum clip duration in seconds
SAMPLES_PER_SEC, 8000, sample_tick rate
(derived localparams: CLIP_SAMPLES=CLIP_SECONDS*SAMPLES_PER_SEC; CLIP_W=$clog2(NUM_CLIPS); CNT_W=$clog2(CLIP_SAMPLES); LEN_W=$clog2(CLIP_SAMPLES+1); ADDR_W=$clog2(NUM_CLIPS*CLIP_SAMPLES))

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
action  input  1  one-cycle start strobe
mode  input  2  00 play, 01 record, 10 erase, 11 reserved
clip_sel  input  CLIP_W  target clip, sampled on accepted action
stop  input  1  abort/finish current record or play
sample_tick  input  1  one-cycle strobe per sample period
busy  output  1  high in RECORD or PLAY
rec_en  output  1  codec ADC/encoder enable (RECORD)
play_en  output  1  codec DAC/decoder enable (PLAY)
mem_we  output  1  sample RAM write enable
mem_addr  output  ADDR_W  sample RAM address
clip_valid  output  NUM_CLIPS  per-clip "holds data" flags
done  output  1  one-cycle pulse on operation completion
err  output  1  one-cycle pulse on rejected command
state_o  output  2  current state (debug)

Behaviour:
- Reset (reset low, async): state IDLE; sample_cnt, cur_clip, all lengths = 0; clip_valid = 0; done, err = 0.
- States: IDLE=00, RECORD=01, PLAY=10 (11 unreachable; decodes to IDLE on next edge).
- Combinational outputs: busy, rec_en, play_en from state; mem_addr = cur_clip*CLIP_SAMPLES + sample_cnt; mem_we = (state==RECORD) & sample_tick. done and err are registered, so they pulse the cycle after the event.
- IDLE, action=1: latch cur_clip=clip_sel, clear sample_cnt.
  - mode 01: clear clip_valid[clip] and its length; go RECORD.
  - mode 00: if clip_valid[clip], go PLAY; else err pulse, stay IDLE.
  - mode 10: clear valid and length, done pulse, stay IDLE.
  - mode 11: ignored, no pulse.
- RECORD:
  - Each sample_tick writes mem_addr, then sample_cnt++.
  - Tick with sample_cnt==CLIP_SAMPLES-1: final write; length=CLIP_SAMPLES, valid=1, done, go IDLE (full clip, no wrap).
  - stop without tick: length=sample_cnt, valid=(sample_cnt!=0), done, go IDLE.
  - stop together with tick: the write happens; length=sample_cnt+1, valid=1, done, go IDLE.
- PLAY:
  - mem_addr presents the current sample; sample_tick advances sample_cnt.
  - Tick with sample_cnt==length-1: done, go IDLE.
  - stop: done, go IDLE; a tick in that same cycle is ignored.
- action while busy: ignored, no err. clip_sel changes mid-operation: no effect (latched value used).
- Erase of an empty clip is legal (done pulse).
- Reset mid-operation: partial recording discarded; all clips invalid.
- Widths: sample_cnt never exceeds CLIP_SAMPLES-1; address arithmetic is unsigned and stays within the slot.

Decomposition:
- Package clip_rec_pkg: state enum (IDLE/RECORD/PLAY), mode constants MODE_PLAY/MODE_REC/MODE_ERASE/MODE_RSVD.
- Sub-module clip_len_table: per-clip valid bits and LEN_W length registers, with write, clear and read-by-index ports. The FSM, sample counter and address generation stay in clip_recorder_ctrl.

Test Plan:
Bench parameters: NUM_CLIPS=4, CLIP_SECONDS=1, SAMPLES_PER_SEC=8 (CLIP_SAMPLES=8).
1. Full record: action, mode=01, clip=2, then 8 ticks -> mem_we on 8 ticks, addrs 16..23; done pulse; clip_valid=0100; back to IDLE.
2. Short record plus stop collision: clip 1, 3 ticks, then stop with a tick in the same cycle -> addrs 8..11 written; length 4; playback of clip 1 issues addrs 8..11, then done.
3. Play empty clip: action, mode=00, clip=3 with clip_valid=0 -> err pulse one cycle later; state stays IDLE; play_en never high.
4. Erase: after scenario 1, action, mode=10, clip=2 -> clip_valid=0000, done pulse; a following play of clip 2 -> err.
5. Busy lockout: during RECORD of clip 0, action, mode=00, clip=1 -> ignored; recording continues to addr 7; no err.
6. Async reset: assert reset mid-PLAY between clock edges -> outputs clear immediately; clip_valid=0; state_o=00.

Source files
------------

// File: rtl/clip_rec_pkg.sv
// Shared types and command encodings for the clip recorder controller.
package clip_rec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } state_t;

  localparam logic [1:0] MODE_PLAY  = 2'b00;
  localparam logic [1:0] MODE_REC   = 2'b01;
  localparam logic [1:0] MODE_ERASE = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

endpackage

// File: rtl/clip_recorder_ctrl_if.sv
// Command, sample-memory and status signals of the clip recorder controller.
interface clip_recorder_ctrl_if #(
  parameter int unsigned NUM_CLIPS       = 4,
  parameter int unsigned CLIP_SECONDS    = 8,
  parameter int unsigned SAMPLES_PER_SEC = 8000
) ();
  localparam int unsigned CLIP_SAMPLES = CLIP_SECONDS * SAMPLES_PER_SEC;
  localparam int unsigned CLIP_W       = $clog2(NUM_CLIPS);
  localparam int unsigned ADDR_W       = $clog2(NUM_CLIPS * CLIP_SAMPLES);

  logic                 action;
  logic [1:0]           mode;
  logic [CLIP_W-1:0]    clip_sel;
  logic                 stop;
  logic                 sample_tick;
  logic                 busy;
  logic                 rec_en;
  logic                 play_en;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [NUM_CLIPS-1:0] clip_valid;
  logic                 done;
  logic                 err;
  logic [1:0]           state_o;

  modport master (
    output action, mode, clip_sel, stop, sample_tick,
    input  busy, rec_en, play_en, mem_we, mem_addr, clip_valid, done, err, state_o
  );

  modport slave (
    input  action, mode, clip_sel, stop, sample_tick,
    output busy, rec_en, play_en, mem_we, mem_addr, clip_valid, done, err, state_o
  );
endinterface

// File: rtl/clip_len_table.sv
// Per-clip valid flags and recorded lengths; clear and write ports, one read port.
module clip_len_table #(
  parameter int unsigned NUM_CLIPS = 4,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned CLIP_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_en_i,
  input  logic [CLIP_W-1:0]    clr_idx_i,
  input  logic                 wr_en_i,
  input  logic [CLIP_W-1:0]    wr_idx_i,
  input  logic [LEN_W-1:0]     wr_len_i,
  input  logic                 wr_valid_i,
  input  logic [CLIP_W-1:0]    rd_idx_i,
  output logic [LEN_W-1:0]     rd_len_o,
  output logic [NUM_CLIPS-1:0] valid_o
);

  logic [NUM_CLIPS-1:0] valid_q;
  logic [LEN_W-1:0]     len_q [NUM_CLIPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NUM_CLIPS); i++) len_q[i] <= '0;
    end else begin
      if (clr_en_i) begin
        valid_q[clr_idx_i] <= 1'b0;
        len_q[clr_idx_i]   <= '0;
      end
      if (wr_en_i) begin
        valid_q[wr_idx_i] <= wr_valid_i;
        len_q[wr_idx_i]   <= wr_len_i;
      end
    end
  end

  assign rd_len_o = len_q[rd_idx_i];
  assign valid_o  = valid_q;

endmodule

// File: rtl/clip_recorder_ctrl.sv
// Record/play/erase sequencer over fixed-size clip slots in sample RAM.
module clip_recorder_ctrl
  import clip_rec_pkg::*;
#(
  parameter int unsigned NUM_CLIPS       = 4,
  parameter int unsigned CLIP_SECONDS    = 8,
  parameter int unsigned SAMPLES_PER_SEC = 8000
) (
  input logic            clock,
  input logic            reset,
  clip_recorder_ctrl_if.slave bus
);
  localparam int unsigned CLIP_SAMPLES = CLIP_SECONDS * SAMPLES_PER_SEC;
  localparam int unsigned CLIP_W       = $clog2(NUM_CLIPS);
  localparam int unsigned CNT_W        = $clog2(CLIP_SAMPLES);
  localparam int unsigned LEN_W        = $clog2(CLIP_SAMPLES + 1);
  localparam int unsigned ADDR_W       = $clog2(NUM_CLIPS * CLIP_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLIP_SAMPLES - 1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CLIP_W-1:0]    clip_q;
  logic                 done_q;
  logic                 err_q;
  logic [NUM_CLIPS-1:0] valid;
  logic [LEN_W-1:0]     cur_len;
  logic                 clr_en;
  logic                 rec_end;
  logic [LEN_W-1:0]     rec_len;
  logic                 rec_valid;

  // Clearing happens on record start and erase; the slot is refilled when recording ends.
  assign clr_en    = (state_q == ST_IDLE) && bus.action &&
                     ((bus.mode == MODE_REC) || (bus.mode == MODE_ERASE));
  assign rec_end   = (state_q == ST_RECORD) &&
                     (bus.stop || (bus.sample_tick && (cnt_q == CNT_LAST)));
  assign rec_len   = bus.sample_tick ? LEN_W'(cnt_q) + LEN_W'(1) : LEN_W'(cnt_q);
  assign rec_valid = bus.sample_tick || (cnt_q != '0);

  clip_len_table #(
    .NUM_CLIPS(NUM_CLIPS),
    .LEN_W    (LEN_W),
    .CLIP_W   (CLIP_W)
  ) u_len_table (
    .clk       (clock),
    .rst_n     (reset),
    .clr_en_i  (clr_en),
    .clr_idx_i (bus.clip_sel),
    .wr_en_i   (rec_end),
    .wr_idx_i  (clip_q),
    .wr_len_i  (rec_len),
    .wr_valid_i(rec_valid),
    .rd_idx_i  (clip_q),
    .rd_len_o  (cur_len),
    .valid_o   (valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clip_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.action) begin
            clip_q <= bus.clip_sel;
            cnt_q  <= '0;
            case (bus.mode)
              MODE_REC:   state_q <= ST_RECORD;
              MODE_PLAY: begin
                if (valid[bus.clip_sel]) state_q <= ST_PLAY;
                else                     err_q   <= 1'b1;
              end
              MODE_ERASE: done_q <= 1'b1;
              default:    ;
            endcase
          end
        end
        ST_RECORD: begin
          if (rec_end) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (bus.sample_tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // stop wins over a coincident tick
          if (bus.stop) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (bus.sample_tick) begin
            if (LEN_W'(cnt_q) == cur_len - LEN_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q == ST_RECORD) || (state_q == ST_PLAY);
  assign bus.rec_en     = (state_q == ST_RECORD);
  assign bus.play_en    = (state_q == ST_PLAY);
  assign bus.mem_we     = (state_q == ST_RECORD) && bus.sample_tick;
  assign bus.mem_addr   = ADDR_W'(clip_q) * ADDR_W'(CLIP_SAMPLES) + ADDR_W'(cnt_q);
  assign bus.clip_valid = valid;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_clip_recorder_ctrl.sv
// Bench for clip_recorder_ctrl: vector table, directed corner sequences, random run vs model.
module tb_clip_recorder_ctrl;
  localparam int NC = 4;
  localparam int CS = 8;

  logic clk;
  logic rst_n;

  clip_recorder_ctrl_if #(.NUM_CLIPS(4), .CLIP_SECONDS(1), .SAMPLES_PER_SEC(8)) bus ();

  clip_recorder_ctrl #(.NUM_CLIPS(4), .CLIP_SECONDS(1), .SAMPLES_PER_SEC(8)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: operation kind, slot, position and per-slot contents.
  int m_op;          // 0 none, 1 recording, 2 playing
  int m_clip;
  int m_pos;
  int m_len   [NC];
  bit m_valid [NC];
  bit m_done;
  bit m_err;

  int obs_we, obs_addr, obs_state, obs_done, obs_err, obs_valid, obs_play;

  typedef struct {
    logic       a;
    logic [1:0] m;
    logic [1:0] c;
    logic       s;
    logic       t;
    logic       we;
    int         addr;
    int         st;
    logic       done;
    logic       err;
    int         vld;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_valid_vec();
    int v = 0;
    for (int i = 0; i < NC; i++) if (m_valid[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    m_op = 0; m_clip = 0; m_pos = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < NC; i++) begin m_len[i] = 0; m_valid[i] = 0; end
  endtask

  // Finish a recording holding n samples.
  task automatic model_close_rec(input int n);
    m_len[m_clip] = n; m_valid[m_clip] = (n != 0); m_done = 1; m_op = 0;
  endtask

  task automatic model_edge(input bit a, input int m, input int c, input bit s, input bit t);
    m_done = 0; m_err = 0;
    if (m_op == 0) begin
      if (a && m != 3) begin
        m_clip = c; m_pos = 0;
        if (m == 1) begin m_valid[c] = 0; m_len[c] = 0; m_op = 1; end
        else if (m == 2) begin m_valid[c] = 0; m_len[c] = 0; m_done = 1; end
        else if (m_valid[c]) m_op = 2;
        else m_err = 1;
      end
    end else if (m_op == 1) begin
      if (t) begin
        if (m_pos + 1 == CS || s) model_close_rec(m_pos + 1);
        else m_pos++;
      end else if (s) model_close_rec(m_pos);
    end else begin
      if (s) begin m_done = 1; m_op = 0; end
      else if (t) begin
        if (m_pos + 1 == m_len[m_clip]) begin m_done = 1; m_op = 0; end
        else m_pos++;
      end
    end
  endtask

  task automatic model_check(input bit t);
    chk("state", obs_state, m_op);
    chk("busy", int'(bus.busy), int'(m_op != 0));
    chk("rec_en", int'(bus.rec_en), int'(m_op == 1));
    chk("play_en", obs_play, int'(m_op == 2));
    chk("mem_we", obs_we, int'(m_op == 1 && t));
    if (m_op != 0) chk("mem_addr", obs_addr, m_clip * CS + m_pos);
    chk("done", obs_done, int'(m_done));
    chk("err", obs_err, int'(m_err));
    chk("clip_valid", obs_valid, model_valid_vec());
  endtask

  task automatic step(input bit a, input int m, input int c, input bit s, input bit t);
    @(negedge clk);
    bus.action = a; bus.mode = 2'(m); bus.clip_sel = 2'(c);
    bus.stop = s; bus.sample_tick = t;
    #1;
    obs_we = int'(bus.mem_we); obs_addr = int'(bus.mem_addr);
    obs_state = int'(bus.state_o); obs_done = int'(bus.done);
    obs_err = int'(bus.err); obs_valid = int'(bus.clip_valid);
    obs_play = int'(bus.play_en);
    model_check(t);
    @(posedge clk);
    model_edge(a, m, c, s, t);
  endtask

  task automatic add(input bit a, input int m, input int c, input bit s, input bit t,
                     input bit we, input int addr, input int st, input bit dn,
                     input bit er, input int vld);
    vec_t v;
    v.a = a; v.m = 2'(m); v.c = 2'(c); v.s = s; v.t = t;
    v.we = we; v.addr = addr; v.st = st; v.done = dn; v.err = er; v.vld = vld;
    tbl.push_back(v);
  endtask

  initial begin
    int err_seen;
    rst_n = 1'b0;
    bus.action = 0; bus.mode = 0; bus.clip_sel = 0; bus.stop = 0; bus.sample_tick = 0;
    model_reset();
    #12;
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_valid", int'(bus.clip_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full record of clip 2, play of empty clip 3, erase of clip 2, play of erased clip 2.
    add(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < CS; i++) add(0, 0, 0, 0, 1, 1, 16 + i, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    foreach (tbl[i]) begin
      step(tbl[i].a, int'(tbl[i].m), int'(tbl[i].c), tbl[i].s, tbl[i].t);
      chk($sformatf("tbl%0d_we", i), obs_we, int'(tbl[i].we));
      if (tbl[i].we) chk($sformatf("tbl%0d_addr", i), obs_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_state", i), obs_state, tbl[i].st);
      chk($sformatf("tbl%0d_done", i), obs_done, int'(tbl[i].done));
      chk($sformatf("tbl%0d_err", i), obs_err, int'(tbl[i].err));
      chk($sformatf("tbl%0d_valid", i), obs_valid, tbl[i].vld);
    end

    // Short record of clip 1 ending with stop+tick, then playback of 4 samples.
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      chk("s2_rec_addr", obs_addr, 8 + i);
    end
    step(0, 0, 0, 1, 1);
    chk("s2_stop_we", obs_we, 1);
    chk("s2_stop_addr", obs_addr, 11);
    step(0, 0, 0, 0, 0);
    chk("s2_done", obs_done, 1);
    chk("s2_valid", obs_valid, 2);
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 3, 0, 1);
      chk("s2_play_en", obs_play, 1);
      chk("s2_play_addr", obs_addr, 8 + i);
    end
    step(0, 0, 0, 0, 0);
    chk("s2_play_done", obs_done, 1);
    chk("s2_play_state", obs_state, 0);

    // Action while recording clip 0 is ignored; recording runs to address 7.
    err_seen = 0;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < CS; i++) begin
      step(i == 3, 0, 1, 0, 1);
      err_seen |= obs_err;
      chk("s5_addr", obs_addr, i);
    end
    step(0, 0, 0, 0, 0);
    err_seen |= obs_err;
    chk("s5_done", obs_done, 1);
    chk("s5_no_err", err_seen, 0);
    chk("s5_valid", obs_valid, 3);

    // Asynchronous reset between edges in the middle of playback.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    bus.sample_tick = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("s6_state", int'(bus.state_o), 0);
    chk("s6_busy", int'(bus.busy), 0);
    chk("s6_play_en", int'(bus.play_en), 0);
    chk("s6_valid", int'(bus.clip_valid), 0);
    chk("s6_addr", int'(bus.mem_addr), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("s6_play_after_rst_err", obs_err, 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
